// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared constants for the bit-serial subtractor and its adder siblings.
package serial_subtractor_4bit_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_subtractor_4bit_fsub.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Borrow when b exceeds a, or when a == b and a borrow is pending.
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output ovf.
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] r_sh_q,   r_sh_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             bout_q,   bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    logic             fs_diff;
    logic             fs_bout;
    logic [WIDTH-1:0] r_next;

    full_subtractor_1bit u_fsub (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    // Next-state: capture on start in IDLE, shift one bit per cycle in SHIFT.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        r_next  = {fs_diff, r_sh_q[WIDTH-1:1]};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    r_sh_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                r_sh_d = r_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = fs_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Result registers only change here, so d/bout hold between completions.
                    d_d     = r_next;
                    bout_d  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB cell is br_q on this last bit.
                    ovf_d   = br_q ^ fs_bout;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed testbench for serial_subtractor_4bit (WIDTH = 4).
module tb_serial_subtractor_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a, b;
    logic       bin;
    logic       busy, done, bout;
    logic [3:0] d;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [4:0] last_exp = 5'd0;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [4:0] exp;   // {bout, d}
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        logic [4:0] r;
        r = {1'b0, ta} - {1'b0, tb} - {4'b0, tbin};
        return r;
    endfunction

    function automatic logic ovf_model(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        int r;
        r = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
        return (r < -8) || (r > 7);
    endfunction

    // One complete operation from a fresh start pulse, with latency/busy/hold checks.
    task automatic run_op(input string nm, input logic [3:0] ta, input logic [3:0] tb,
                          input logic tbin, input logic [4:0] exp);
        int cyc;
        int nbusy;
        int hold_bad;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; bin = ~tbin;
        cyc = 0; nbusy = 0; hold_bad = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            if ({bout, d} != last_exp) hold_bad++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, cyc, 4);
        chk({nm, " busy_cycles"}, nbusy, 4);
        chk({nm, " hold"}, hold_bad, 0);
        chk({nm, " result"}, int'({bout, d}), int'(exp));
        chk({nm, " busy_at_done"}, int'(busy), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, " ovf"}, int'(ovf), int'(ovf_model(ta, tb, tbin)));
`endif
        @(negedge clk);
        chk({nm, " done_one_cycle"}, int'(done), 0);
        last_exp = exp;
    endtask

    vec_t vecs[8];
    logic [3:0] oa, ob;
    logic       obin;
    logic [4:0] pending;
    int         seen_done;

    initial begin
        vecs[0] = '{4'b1001, 4'b0101, 1'b0, 5'b0_0100};
        vecs[1] = '{4'b0101, 4'b1001, 1'b0, 5'b1_1100};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 5'b1_1111};
        vecs[3] = '{4'b1111, 4'b1111, 1'b0, 5'b0_0000};
        vecs[4] = '{4'b0111, 4'b1111, 1'b0, 5'b1_1000};
        vecs[5] = '{4'b1000, 4'b0001, 1'b0, 5'b0_0111};
        vecs[6] = '{4'b0011, 4'b0001, 1'b0, 5'b0_0010};
        vecs[7] = '{4'b0000, 4'b0001, 1'b1, 5'b1_1110};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset d", int'(d), 0);
        chk("reset bout", int'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset ovf", int'(ovf), 0);
`endif
        rst_n = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);

        // Start held high (toggling while busy): a capture every 5th edge, operands changing each cycle
        pending = '0;
        for (int t = 0; t <= 25; t++) begin
            @(negedge clk);
            if (t > 0) begin
                if (t % 5 == 0) begin
                    chk($sformatf("held done t%0d", t), int'(done), 1);
                    chk($sformatf("held result t%0d", t), int'({bout, d}), int'(pending));
                end else begin
                    chk($sformatf("held no_done t%0d", t), int'(done), 0);
                end
            end
            if (t < 25) begin
                oa = 4'($urandom); ob = 4'($urandom); obin = 1'($urandom);
                a = oa; b = ob; bin = obin;
                start = (t % 5 == 0) ? 1'b1 : 1'($urandom);
                if (t % 5 == 0) pending = model(oa, ob, obin);
            end else begin
                start = 1'b0;
            end
        end
        last_exp = pending;

        // Make the held result nonzero so the reset clear is visible
        run_op("pre_reset", 4'b1001, 4'b0101, 1'b0, 5'b0_0100);

        // Reset during the 2nd SHIFT cycle
        @(negedge clk);
        a = 4'b0110; b = 4'b0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort d", int'(d), 0);
        chk("abort bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort no_done", seen_done, 0);
        last_exp = '0;
        run_op("post_reset", 4'b0110, 4'b0001, 1'b0, 5'b0_0101);

        // Exhaustive sweep
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op($sformatf("sweep %0d-%0d-%0d", ia, ib, ic), 4'(ia), 4'(ib), 1'(ic),
                           model(4'(ia), 4'(ib), 1'(ic)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
